// File: rtl/imem_writer.sv
// imem_writer: byte-addressed instruction memory with a valid/ready word writer
// and a combinational big-endian fetch port.
module imem_writer #(
   parameter int ADDR_BITS = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wr_valid,
   output logic        wr_ready,
   input  logic [31:0] wr_addr,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic        misaligned,
   output logic [15:0] word_count,
   input  logic [31:0] pc,
   output logic [31:0] instruction
);
   typedef enum logic {IDLE, WRITE} state_t;
   state_t                 state;
   logic [1:0]             k;
   logic [ADDR_BITS-1:0]   base;
   logic [31:0]            data;
   logic [7:0]             mem [0:2**ADDR_BITS-1];
   logic [ADDR_BITS-1:0]   adr;
   logic [7:0]             wr_byte;
   logic                   unused;
   assign unused = ^{pc[31:ADDR_BITS], pc[1:0], wr_addr[31:ADDR_BITS]};
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         k          <= 2'd0;
         base       <= '0;
         data       <= '0;
         wr_ready   <= 1'b1;
         busy       <= 1'b0;
         misaligned <= 1'b0;
         word_count <= 16'd0;
      end else if (state == IDLE) begin
         if (wr_valid) begin
            base     <= {wr_addr[ADDR_BITS-1:2], 2'b00};
            data     <= wr_data;
            k        <= 2'd0;
            state    <= WRITE;
            wr_ready <= 1'b0;
            busy     <= 1'b1;
            if (|wr_addr[1:0]) misaligned <= 1'b1;
         end
      end else begin
         k <= k + 2'd1;
         if (k == 2'd3) begin
            state      <= IDLE;
            wr_ready   <= 1'b1;
            busy       <= 1'b0;
            word_count <= word_count + 16'd1;
         end
      end
   end
   // byte k of the word, most significant first
   assign wr_byte = data[{~k, 3'b000} +: 8];
   // array has no reset; an async reset drops state to IDLE so no further bytes land
   always_ff @(posedge clk) begin
      if (state == WRITE) mem[base + ADDR_BITS'(k)] <= wr_byte;
   end
   assign adr = {pc[ADDR_BITS-1:2], 2'b00};
   assign instruction = {mem[adr], mem[adr + ADDR_BITS'(1)],
                         mem[adr + ADDR_BITS'(2)], mem[adr + ADDR_BITS'(3)]};
endmodule
